// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data memory controller: core-side request/response
// structs, controller FSM states and the out-of-range response word.
package data_mem_ctrl_pkg;

   typedef struct packed {
      logic [31:0] write_data;
      logic        valid;
      logic        wen;
      logic        byte_not_word;
      logic        yumi;
   } mem_in_s;

   typedef struct packed {
      logic [31:0] read_data;
      logic        valid;
      logic        yumi;
   } mem_out_s;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_e;

   localparam logic [31:0] dmem_err_data_gp = 32'hDEAD_BEEF;

   // Byte-lane write enables: one little-endian lane for byte ops, all four for words.
   function automatic logic [3:0] lane_mask(input logic byte_not_word, input logic [1:0] lane);
      if (byte_not_word) begin
         return 4'b0001 << lane;
      end else begin
         return 4'b1111;
      end
   endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Core <-> data memory handshake bundle: request struct, byte address, response struct.
interface data_mem_ctrl_if;
   import data_mem_ctrl_pkg::*;

   mem_in_s     to_mem_i;
   logic [31:0] addr_i;
   mem_out_s    from_mem_o;

   modport master (output to_mem_i, output addr_i, input from_mem_o);
   modport slave  (input to_mem_i, input addr_i, output from_mem_o);

endinterface

// File: rtl/data_mem_ctrl_dmem_array.sv
// dmem_array: 2^addr_width_p x 32 single-port RAM, synchronous read, per-byte write enable.
module dmem_array #(
   parameter int addr_width_p = 10
) (
   input  logic                    clk,
   input  logic                    en,
   input  logic [3:0]              we,
   input  logic [addr_width_p-1:0] addr,
   input  logic [31:0]             wdata,
   output logic [31:0]             rdata
);

   logic [31:0] mem_r [2**addr_width_p];
   logic [31:0] rdata_r;

   // Lane-masked write; a read only when no lane is written so the last load stays on rdata.
   always_ff @(posedge clk) begin
      if (en) begin
         for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
               mem_r[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
         end
         if (we == 4'b0000) begin
            rdata_r <= mem_r[addr];
         end
      end
   end

   assign rdata = rdata_r;

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: one-request-at-a-time data memory with fixed latency and held response.
// Optional out-of-range checking and sticky err_o are enabled by defining DMEM_ADDR_CHECK_EN.
module data_mem_ctrl
   import data_mem_ctrl_pkg::*;
#(
   parameter int addr_width_p = 10,
   parameter int latency_p    = 2
) (
   input  logic            clk,
   input  logic            reset,
   data_mem_ctrl_if.slave  mem_bus
`ifdef DMEM_ADDR_CHECK_EN
   ,
   output logic            err_o
`endif
);

   localparam logic [3:0] lat_load_lp = 4'(latency_p - 1);

   dmem_state_e             state_r, state_s;
   logic [3:0]              cnt_r;
   logic [addr_width_p+1:0] addr_r;
   logic [31:0]             wdata_r;
   logic                    wen_r, bnw_r;
   logic                    yumi_s, accept_s, access_s, oor_s;
   logic                    arr_en_s;
   logic [3:0]              arr_we_s;
   logic [31:0]             arr_wdata_s, arr_rdata_s, rd_s;

`ifdef DMEM_ADDR_CHECK_EN
   logic oor_r;
   logic err_r;
   assign oor_s = oor_r;
   assign err_o = err_r;

   // Out-of-range flag rides with the captured request; err is sticky until reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         oor_r <= 1'b0;
         err_r <= 1'b0;
      end else begin
         if (accept_s) begin
            oor_r <= |mem_bus.addr_i[31:addr_width_p+2];
         end
         if (access_s && oor_r) begin
            err_r <= 1'b1;
         end
      end
   end
`else
   logic addr_hi_unused_s;
   assign addr_hi_unused_s = ^mem_bus.addr_i[31:addr_width_p+2];
   assign oor_s = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next state, accept and access strobes.
   always_comb begin
      state_s  = state_r;
      yumi_s   = 1'b0;
      accept_s = 1'b0;
      access_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (mem_bus.to_mem_i.valid) begin
               yumi_s   = 1'b1;
               accept_s = 1'b1;
               state_s  = WAIT;
            end else begin
               state_s  = IDLE;
            end
         end
         WAIT: begin
            if (cnt_r == 4'd0) begin
               access_s = 1'b1;
               state_s  = RESP;
            end else begin
               state_s  = WAIT;
            end
         end
         RESP: begin
            if (mem_bus.to_mem_i.yumi) begin
               state_s = IDLE;
            end else begin
               state_s = RESP;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // Request capture and latency countdown.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_r   <= 4'd0;
         addr_r  <= '0;
         wdata_r <= 32'd0;
         wen_r   <= 1'b0;
         bnw_r   <= 1'b0;
      end else if (accept_s) begin
         cnt_r   <= lat_load_lp;
         addr_r  <= mem_bus.addr_i[addr_width_p+1:0];
         wdata_r <= mem_bus.to_mem_i.write_data;
         wen_r   <= mem_bus.to_mem_i.wen;
         bnw_r   <= mem_bus.to_mem_i.byte_not_word;
      end else if ((state_r == WAIT) && (cnt_r != 4'd0)) begin
         cnt_r   <= cnt_r - 4'd1;
      end
   end

   // A reset landing on the access cycle must not let the write through.
   assign arr_en_s    = access_s & reset & ~oor_s;
   assign arr_we_s    = wen_r ? lane_mask(bnw_r, addr_r[1:0]) : 4'b0000;
   assign arr_wdata_s = bnw_r ? {4{wdata_r[7:0]}} : wdata_r;

   dmem_array #(.addr_width_p(addr_width_p)) u_array (
      .clk   (clk),
      .en    (arr_en_s),
      .we    (arr_we_s),
      .addr  (addr_r[addr_width_p+1:2]),
      .wdata (arr_wdata_s),
      .rdata (arr_rdata_s)
   );

   // Response data: zero outside RESP and for stores, lane-extracted for byte loads.
   always_comb begin
      rd_s = 32'd0;
      if (state_r != RESP) begin
         rd_s = 32'd0;
      end else if (wen_r) begin
         rd_s = 32'd0;
      end else if (oor_s) begin
         rd_s = dmem_err_data_gp;
      end else if (bnw_r) begin
         rd_s = {24'd0, arr_rdata_s[{addr_r[1:0], 3'b000} +: 8]};
      end else begin
         rd_s = arr_rdata_s;
      end
   end

   assign mem_bus.from_mem_o = '{read_data: rd_s, valid: (state_r == RESP), yumi: yumi_s};

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: port 0 runs latency 2, port 1 runs latency 1.
module tb_data_mem_ctrl;
   import data_mem_ctrl_pkg::*;

   localparam int AW     = 10;
   localparam int LAT[2] = '{2, 1};

   typedef struct {
      logic [31:0] rd;
      int          cyc;
      int          dly;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        core_valid[2], core_wen[2], core_bnw[2], core_yumi[2];
   logic [31:0] core_wd[2], core_addr[2];
   mem_out_s    rsp[2];

   data_mem_ctrl_if bus0 ();
   data_mem_ctrl_if bus1 ();

   assign bus0.to_mem_i = '{write_data: core_wd[0], valid: core_valid[0], wen: core_wen[0],
                            byte_not_word: core_bnw[0], yumi: core_yumi[0]};
   assign bus0.addr_i   = core_addr[0];
   assign bus1.to_mem_i = '{write_data: core_wd[1], valid: core_valid[1], wen: core_wen[1],
                            byte_not_word: core_bnw[1], yumi: core_yumi[1]};
   assign bus1.addr_i   = core_addr[1];
   assign rsp[0] = bus0.from_mem_o;
   assign rsp[1] = bus1.from_mem_o;

`ifdef DMEM_ADDR_CHECK_EN
   logic err0, err1;
`endif

   data_mem_ctrl #(.addr_width_p(AW), .latency_p(2)) dut0 (
      .clk     (clk),
      .reset   (reset),
      .mem_bus (bus0)
`ifdef DMEM_ADDR_CHECK_EN
      , .err_o (err0)
`endif
   );

   data_mem_ctrl #(.addr_width_p(AW), .latency_p(1)) dut1 (
      .clk     (clk),
      .reset   (reset),
      .mem_bus (bus1)
`ifdef DMEM_ADDR_CHECK_EN
      , .err_o (err1)
`endif
   );

   exp_t        exp_q0[$];
   exp_t        exp_q1[$];
   int          total = 0;
   int          bad = 0;
   int          hold[2];
   int          cur_dly[2];
   int          last_retire[2];
   logic [31:0] saved[2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         for (int p = 0; p < 2; p++) begin
            if (rsp[p].valid === 1'b1) begin
               check("valid_yumi_exclusive", {31'd0, rsp[p].yumi}, 32'd0);
               if (hold[p] == 0) begin
                  if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
                     total++;
                     bad++;
                     $display("FAIL unexpected_resp: port %0d got data %h at cycle %0d, required no response", p, rsp[p].read_data, cyc);
                     cur_dly[p] = 0;
                  end else begin
                     if (p == 0) e = exp_q0.pop_front();
                     else        e = exp_q1.pop_front();
                     check("resp_data", rsp[p].read_data, e.rd);
                     check("resp_cycle", cyc, e.cyc);
                     cur_dly[p] = e.dly;
                  end
                  saved[p] = rsp[p].read_data;
               end else begin
                  check("resp_hold", rsp[p].read_data, saved[p]);
               end
               if (hold[p] >= cur_dly[p]) begin
                  core_yumi[p]   = 1'b1;
                  last_retire[p] = cyc;
                  hold[p]        = 0;
               end else begin
                  core_yumi[p]   = 1'b0;
                  hold[p]++;
               end
            end else begin
               core_yumi[p] = 1'b0;
               hold[p]      = 0;
            end
         end
      end
   endtask

   task automatic issue(input int p, input logic w, input logic b, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input int dly,
                        input bit push, output int acc);
      int   budget;
      exp_t e;
      @(negedge clk);
      core_valid[p] = 1'b1;
      core_wen[p]   = w;
      core_bnw[p]   = b;
      core_addr[p]  = a;
      core_wd[p]    = wd;
      #1;
      budget = 0;
      while (rsp[p].yumi !== 1'b1 && budget < 100) begin
         @(negedge clk);
         #1;
         budget++;
      end
      total++;
      if (rsp[p].yumi !== 1'b1) begin
         bad++;
         acc = -1;
         $display("FAIL accept_timeout: port %0d addr %h got no yumi, required yumi", p, a);
      end else begin
         acc = cyc;
         if (push) begin
            e.rd  = exp_rd;
            e.cyc = cyc + LAT[p] + 1;
            e.dly = dly;
            if (p == 0) exp_q0.push_back(e);
            else        exp_q1.push_back(e);
         end
      end
      @(posedge clk);
      #1;
      core_valid[p] = 1'b0;
      core_wen[p]   = 1'b0;
      core_bnw[p]   = 1'b0;
   endtask

   task automatic wait_idle();
      int budget = 0;
      while (budget < 200 && (exp_q0.size() != 0 || exp_q1.size() != 0 ||
                              rsp[0].valid !== 1'b0 || rsp[1].valid !== 1'b0)) begin
         @(negedge clk);
         budget++;
      end
      if (budget >= 200) begin
         total++;
         bad++;
         $display("FAIL idle_timeout: got %0d/%0d responses outstanding, required 0", exp_q0.size(), exp_q1.size());
      end
      @(negedge clk);
   endtask

   task automatic run();
      int acc[4];
      logic [31:0] alias_exp;

      // 1: word store then word load, latency 2
      issue(0, 1'b1, 1'b0, 32'h10, 32'h1234_5678, 32'h0, 0, 1'b1, acc[0]);
      issue(0, 1'b0, 1'b0, 32'h10, 32'h0, 32'h1234_5678, 0, 1'b1, acc[0]);
      // 2: byte store to lane 3, then word and byte loads
      issue(0, 1'b1, 1'b1, 32'h13, 32'hFFFF_FFAB, 32'h0, 0, 1'b1, acc[0]);
      issue(0, 1'b0, 1'b0, 32'h12, 32'h0, 32'hAB34_5678, 0, 1'b1, acc[0]);
      issue(0, 1'b0, 1'b1, 32'h13, 32'h0, 32'h0000_00AB, 0, 1'b1, acc[0]);
      issue(0, 1'b0, 1'b1, 32'h11, 32'h0, 32'h0000_0056, 0, 1'b1, acc[0]);
      // 3: core holds off yumi 5 cycles; queued request waits for retirement
      issue(0, 1'b0, 1'b0, 32'h10, 32'h0, 32'hAB34_5678, 5, 1'b1, acc[0]);
      issue(0, 1'b0, 1'b1, 32'h10, 32'h0, 32'h0000_0078, 0, 1'b1, acc[1]);
      check("accept_after_retire", acc[1], last_retire[0] + 1);
      wait_idle();
      // 4: reset on the access cycle of a pending store
      issue(0, 1'b1, 1'b0, 32'h10, 32'hFFFF_FFFF, 32'h0, 0, 1'b0, acc[0]);
      @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      repeat (4) @(negedge clk);
      check("no_resp_after_reset", {31'd0, rsp[0].valid}, 32'd0);
      issue(0, 1'b0, 1'b0, 32'h10, 32'h0, 32'hAB34_5678, 0, 1'b1, acc[0]);
      wait_idle();
`ifdef DMEM_ADDR_CHECK_EN
      check("err_before_oor", {31'd0, err0}, 32'd0);
      alias_exp = dmem_err_data_gp;
`else
      alias_exp = 32'h5A5A_1234;
`endif
      // 5: word index 2^AW
      issue(0, 1'b1, 1'b0, 32'h0, 32'h5A5A_1234, 32'h0, 0, 1'b1, acc[0]);
      issue(0, 1'b0, 1'b0, 32'h1000, 32'h0, alias_exp, 0, 1'b1, acc[0]);
      wait_idle();
`ifdef DMEM_ADDR_CHECK_EN
      check("err_set", {31'd0, err0}, 32'd1);
      issue(0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h5A5A_1234, 0, 1'b1, acc[0]);
      wait_idle();
      check("err_sticky", {31'd0, err0}, 32'd1);
`endif
      // 6: latency 1, back-to-back with immediate yumi
      issue(1, 1'b1, 1'b0, 32'h0, 32'h1111_1111, 32'h0, 0, 1'b1, acc[0]);
      issue(1, 1'b1, 1'b0, 32'h4, 32'h2222_2222, 32'h0, 0, 1'b1, acc[1]);
      issue(1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h1111_1111, 0, 1'b1, acc[2]);
      issue(1, 1'b0, 1'b0, 32'h4, 32'h0, 32'h2222_2222, 0, 1'b1, acc[3]);
      for (int i = 1; i < 4; i++) begin
         check("accept_spacing", acc[i] - acc[i-1], 32'd3);
      end
      wait_idle();
   endtask

   initial begin
      for (int p = 0; p < 2; p++) begin
         core_valid[p]  = 1'b0;
         core_wen[p]    = 1'b0;
         core_bnw[p]    = 1'b0;
         core_yumi[p]   = 1'b0;
         core_wd[p]     = 32'd0;
         core_addr[p]   = 32'd0;
         hold[p]        = 0;
         cur_dly[p]     = 0;
         last_retire[p] = 0;
         saved[p]       = 32'd0;
      end
      reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
         check("reset_valid", {31'd0, rsp[p].valid}, 32'd0);
         check("reset_read_data", rsp[p].read_data, 32'd0);
         check("reset_yumi", {31'd0, rsp[p].yumi}, 32'd0);
      end
`ifdef DMEM_ADDR_CHECK_EN
      check("reset_err", {31'd0, err0}, 32'd0);
`endif
      reset = 1'b1;
      fork
         monitor();
         run();
      join_any
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
